// File: rtl/beehive_noc_arb_pkg.sv
// ---------------------------------------------------------------------------
// beehive_noc_arb_pkg
// Shared definitions for the packet-atomic NoC round-robin arbiter:
//   NOC_DATA_WIDTH   default flit width
//   NOC_MSG_LEN_LSB  LSB of the msg_len field (body flits after header)
//   NOC_MSG_LEN_W    width of the msg_len field
//   arb_state_e      arbiter FSM states
// ---------------------------------------------------------------------------
package beehive_noc_arb_pkg;

   localparam int NOC_DATA_WIDTH  = 64;
   localparam int NOC_MSG_LEN_LSB = 22;
   localparam int NOC_MSG_LEN_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/beehive_noc_rr_pkt_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_prio_picker
// Rotated priority encoder: returns the first asserted request searching
// ptr, ptr+1, ... wrapping modulo N. Purely combinational.
//   req      in   N     request vector
//   ptr      in   IW    index with highest priority this cycle
//   gnt_idx  out  IW    winning index (0 when nothing requests)
//   gnt_val  out  1     at least one request asserted
// ---------------------------------------------------------------------------
module rr_prio_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_val
);

   int idx;

   // Walk from the farthest offset back to the nearest so the nearest
   // requester after ptr is the last (and therefore winning) assignment.
   always_comb begin
      gnt_idx = '0;
      gnt_val = 1'b0;
      idx     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_idx = IW'(idx);
            gnt_val = 1'b1;
         end
      end
   end

endmodule

// File: rtl/beehive_noc_rr_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// beehive_noc_rr_pkt_arbiter
// Packet-atomic round-robin arbiter merging NUM_SRCS val/rdy flit streams
// onto one NoC output. A grant is held from the header flit through the
// last body flit of a message; the message length is read from the header.
// Per-source completed-message counters are provided for stats readout.
//   clk           in   1                 clock
//   rst           in   1                 synchronous active-high reset
//   src_arb_val   in   NUM_SRCS          per-source flit valid
//   src_arb_data  in   NUM_SRCS*DATA_W   per-source flit, source i at [i*DATA_W +: DATA_W]
//   arb_src_rdy   out  NUM_SRCS          per-source ready
//   arb_dst_val   out  1                 output flit valid
//   arb_dst_data  out  DATA_W            output flit
//   dst_arb_rdy   in   1                 downstream ready
//   arb_msg_cnt   out  NUM_SRCS*CNT_W    messages completed per source (wraps)
// ---------------------------------------------------------------------------
module beehive_noc_rr_pkt_arbiter
   import beehive_noc_arb_pkg::*;
#(
   parameter int NUM_SRCS = 2,
   parameter int DATA_W   = NOC_DATA_WIDTH,
   parameter int LEN_LSB  = NOC_MSG_LEN_LSB,
   parameter int LEN_W    = NOC_MSG_LEN_W,
   parameter int CNT_W    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRCS-1:0]          src_arb_val,
   input  logic [NUM_SRCS*DATA_W-1:0]   src_arb_data,
   output logic [NUM_SRCS-1:0]          arb_src_rdy,
   output logic                         arb_dst_val,
   output logic [DATA_W-1:0]            arb_dst_data,
   input  logic                         dst_arb_rdy,
   output logic [NUM_SRCS*CNT_W-1:0]    arb_msg_cnt
);

   localparam int              IDX_W    = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRCS - 1);

   arb_state_e                         state_q, state_d;
   logic [IDX_W-1:0]                   grant_q, grant_d;
   logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]                   flits_left_q, flits_left_d;

   logic [NUM_SRCS-1:0][DATA_W-1:0]    src_data;
   logic [IDX_W-1:0]                   pick_idx;
   logic                               pick_val;
   logic [IDX_W-1:0]                   sel;
   logic [IDX_W-1:0]                   sel_inc;
   logic                               sel_val;
   logic                               sel_live;
   logic                               hs;
   logic                               msg_done;
   logic [LEN_W-1:0]                   hdr_len;

   assign src_data = src_arb_data;

   rr_prio_picker #(
      .N  (NUM_SRCS),
      .IW (IDX_W)
   ) u_picker (
      .req     (src_arb_val),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx),
      .gnt_val (pick_val)
   );

   // Source selection: free choice in IDLE, locked to the grant otherwise.
   // sel_live marks that sel names a real owner (so its rdy may be driven
   // even through a bubble in the body).
   always_comb begin
      sel      = pick_idx;
      sel_val  = pick_val;
      sel_live = pick_val;
      if (state_q != IDLE) begin
         sel      = grant_q;
         sel_val  = src_arb_val[grant_q];
         sel_live = 1'b1;
      end
   end

   // Output mux; reset forces the handshake off even though the path is
   // combinational from the sources.
   always_comb begin
      arb_dst_val  = ~rst & sel_val;
      arb_dst_data = src_data[sel];
      arb_src_rdy  = '0;
      if (~rst & sel_live)
         arb_src_rdy[sel] = dst_arb_rdy;
   end

   assign hs      = arb_dst_val & dst_arb_rdy;
   assign hdr_len = arb_dst_data[LEN_LSB +: LEN_W];
   assign sel_inc = (sel == LAST_IDX) ? '0 : sel + 1'b1;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      flits_left_d = flits_left_q;
      msg_done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               if (hdr_len == '0) begin
                  msg_done = 1'b1;
               end else begin
                  flits_left_d = hdr_len;
                  grant_d      = sel;
                  state_d      = BODY;
               end
            end else if (pick_val) begin
               // Header offered but stalled: lock it so a later-arriving
               // source cannot swap the flit under a pending valid.
               grant_d = sel;
               state_d = HDR;
            end
         end
         HDR: begin
            if (hs) begin
               if (hdr_len == '0) begin
                  msg_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  flits_left_d = hdr_len;
                  state_d      = BODY;
               end
            end
         end
         BODY: begin
            if (hs) begin
               flits_left_d = flits_left_q - 1'b1;
               if (flits_left_q == LEN_W'(1)) begin
                  msg_done = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (msg_done)
         rr_ptr_d = sel_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         flits_left_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         flits_left_q <= flits_left_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (msg_done && (sel == IDX_W'(gi)))
               cnt_d = cnt_q + 1'b1;
         end

         always_ff @(posedge clk) begin
            if (rst)
               cnt_q <= '0;
            else
               cnt_q <= cnt_d;
         end

         assign arb_msg_cnt[gi*CNT_W +: CNT_W] = cnt_q;
      end
   endgenerate

endmodule

// File: tb/tb_beehive_noc_rr_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_beehive_noc_rr_pkt_arbiter
// Directed bench for the two-source round-robin packet arbiter. Flits carry
// {src, msg, idx} tags in the upper bytes and msg_len in bits [29:22], so
// every expected output word is rebuilt from constants.
// ---------------------------------------------------------------------------
module tb_beehive_noc_rr_pkt_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    src_val = '0;
   logic [127:0]  src_data = '0;
   logic [1:0]    src_rdy;
   logic          dst_val;
   logic [63:0]   dst_data;
   logic          dst_rdy = 1'b0;
   logic [63:0]   msg_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   beehive_noc_rr_pkt_arbiter #(
      .NUM_SRCS (2),
      .DATA_W   (64),
      .LEN_LSB  (22),
      .LEN_W    (8),
      .CNT_W    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .src_arb_val  (src_val),
      .src_arb_data (src_data),
      .arb_src_rdy  (src_rdy),
      .arb_dst_val  (dst_val),
      .arb_dst_data (dst_data),
      .dst_arb_rdy  (dst_rdy),
      .arb_msg_cnt  (msg_cnt)
   );

   function automatic logic [63:0] mk_flit(input int s, input int m, input int i, input int len);
      logic [63:0] f;
      f        = '0;
      f[63:56] = 8'(s);
      f[55:48] = 8'(m);
      f[47:40] = 8'(i);
      f[29:22] = 8'(len);
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic v, input logic [63:0] d);
      src_val[s]          = v;
      src_data[s*64 +: 64] = d;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      src_val  = '0;
      src_data = '0;
      dst_rdy  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      dst_rdy = 1'b0;
      set_src(0, 1'b1, mk_flit(0, 0, 0, 2));
      set_src(1, 1'b1, mk_flit(1, 0, 0, 2));
      for (int c = 0; c < 2; c++) begin
         tick();
         tests_run++;
         if (dst_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_val c=%0d got=%b exp=0", c, dst_val);
         end
         tests_run++;
         if (src_rdy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_rdy c=%0d got=%b exp=00", c, src_rdy);
         end
         tests_run++;
         if (msg_cnt !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_cnt c=%0d got=%h exp=0", c, msg_cnt);
         end
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (dst_val !== 1'b1 || dst_data !== mk_flit(0, 0, 0, 2)) begin
         tests_failed++;
         $display("FAIL reset_release val=%b data=%h exp val=1 data=%h", dst_val, dst_data, mk_flit(0, 0, 0, 2));
      end
      $display("[TB] reset: released, header out val=%b data=%h", dst_val, dst_data);
   endtask

   task automatic test_fairness();
      int ff[2];
      int mm[2];
      logic [63:0] exp_d;
      do_reset();
      ff[0] = 0; ff[1] = 0; mm[0] = 0; mm[1] = 0;
      dst_rdy = 1'b1;
      for (int c = 0; c < 12; c++) begin
         int es;
         int ei;
         int em;
         es = (c / 3) % 2;
         ei = c % 3;
         em = c / 6;
         for (int s = 0; s < 2; s++)
            set_src(s, 1'b1, mk_flit(s, mm[s], ff[s], (ff[s] == 0) ? 2 : 0));
         exp_d = mk_flit(es, em, ei, (ei == 0) ? 2 : 0);
         #1;
         tests_run++;
         if (dst_val !== 1'b1 || dst_data !== exp_d) begin
            tests_failed++;
            $display("FAIL fair_data c=%0d val=%b got=%h exp=%h", c, dst_val, dst_data, exp_d);
         end
         tests_run++;
         if (src_rdy !== 2'(1 << es)) begin
            tests_failed++;
            $display("FAIL fair_rdy c=%0d got=%b exp=%b", c, src_rdy, 2'(1 << es));
         end
         $display("[TB] fair: c=%0d src=%0d msg=%0d flit=%0d", c, dst_data[63:56], dst_data[55:48], dst_data[47:40]);
         ff[es]++;
         if (ff[es] == 3) begin
            ff[es] = 0;
            mm[es]++;
         end
         tick();
      end
      tests_run++;
      if (msg_cnt[31:0] !== 32'd2 || msg_cnt[63:32] !== 32'd2) begin
         tests_failed++;
         $display("FAIL fair_cnt got cnt0=%0d cnt1=%0d exp 2/2", msg_cnt[31:0], msg_cnt[63:32]);
      end
   endtask

   task automatic test_atomicity();
      logic [7:0] pat;
      int k;
      do_reset();
      pat     = 8'b1100_1101;   // s0 valid pattern, bit 0 first: 1,0,1,1,0,0,1,1
      k       = 0;
      dst_rdy = 1'b1;
      set_src(1, 1'b1, mk_flit(1, 0, 0, 0));
      for (int c = 0; c < 8; c++) begin
         set_src(0, pat[c], mk_flit(0, 0, k, (k == 0) ? 4 : 0));
         #1;
         tests_run++;
         if (pat[c]) begin
            if (dst_val !== 1'b1 || dst_data !== mk_flit(0, 0, k, (k == 0) ? 4 : 0) || src_rdy !== 2'b01) begin
               tests_failed++;
               $display("FAIL atom_flit c=%0d val=%b rdy=%b got=%h exp=%h", c, dst_val, src_rdy, dst_data, mk_flit(0, 0, k, (k == 0) ? 4 : 0));
            end
            $display("[TB] atom: c=%0d s0 flit=%0d", c, k);
            k++;
         end else begin
            if (dst_val !== 1'b0 || src_rdy[1] !== 1'b0) begin
               tests_failed++;
               $display("FAIL atom_bubble c=%0d val=%b rdy=%b exp val=0 rdy1=0", c, dst_val, src_rdy);
            end
            $display("[TB] atom: c=%0d bubble", c);
         end
         tick();
      end
      set_src(0, 1'b0, '0);
      #1;
      tests_run++;
      if (dst_val !== 1'b1 || dst_data !== mk_flit(1, 0, 0, 0) || src_rdy !== 2'b10) begin
         tests_failed++;
         $display("FAIL atom_next val=%b rdy=%b got=%h exp=%h", dst_val, src_rdy, dst_data, mk_flit(1, 0, 0, 0));
      end
      tests_run++;
      if (msg_cnt[31:0] !== 32'd1) begin
         tests_failed++;
         $display("FAIL atom_cnt0 got=%0d exp=1", msg_cnt[31:0]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      dst_rdy = 1'b0;
      set_src(1, 1'b1, mk_flit(1, 3, 0, 1));
      for (int c = 0; c < 5; c++) begin
         if (c == 2)
            set_src(0, 1'b1, mk_flit(0, 7, 0, 0));
         #1;
         tests_run++;
         if (dst_val !== 1'b1 || dst_data !== mk_flit(1, 3, 0, 1) || src_rdy !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_hold c=%0d val=%b rdy=%b got=%h exp=%h", c, dst_val, src_rdy, dst_data, mk_flit(1, 3, 0, 1));
         end
         $display("[TB] bp: c=%0d stalled header src=%0d", c, dst_data[63:56]);
         tick();
      end
      dst_rdy = 1'b1;
      #1;
      tests_run++;
      if (dst_data !== mk_flit(1, 3, 0, 1) || src_rdy !== 2'b10) begin
         tests_failed++;
         $display("FAIL bp_accept rdy=%b got=%h exp rdy=10 data=%h", src_rdy, dst_data, mk_flit(1, 3, 0, 1));
      end
      tick();
      set_src(1, 1'b1, mk_flit(1, 3, 1, 0));
      #1;
      tests_run++;
      if (dst_data !== mk_flit(1, 3, 1, 0) || src_rdy !== 2'b10) begin
         tests_failed++;
         $display("FAIL bp_body rdy=%b got=%h exp rdy=10 data=%h", src_rdy, dst_data, mk_flit(1, 3, 1, 0));
      end
      tick();
      set_src(1, 1'b0, '0);
      #1;
      tests_run++;
      if (dst_val !== 1'b1 || dst_data !== mk_flit(0, 7, 0, 0) || src_rdy !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_rr val=%b rdy=%b got=%h exp=%h", dst_val, src_rdy, dst_data, mk_flit(0, 7, 0, 0));
      end
      $display("[TB] bp: s1 message done, s0 header out");
   endtask

   task automatic test_zero_len();
      do_reset();
      dst_rdy = 1'b1;
      for (int m = 0; m < 3; m++) begin
         set_src(0, 1'b1, mk_flit(0, m, 0, 0));
         #1;
         tests_run++;
         if (dst_val !== 1'b1 || dst_data !== mk_flit(0, m, 0, 0) || src_rdy !== 2'b01) begin
            tests_failed++;
            $display("FAIL zlen_flit m=%0d val=%b rdy=%b got=%h exp=%h", m, dst_val, src_rdy, dst_data, mk_flit(0, m, 0, 0));
         end
         $display("[TB] zlen: msg=%0d single-flit", m);
         tick();
      end
      set_src(0, 1'b0, '0);
      #1;
      tests_run++;
      if (msg_cnt[31:0] !== 32'd3 || msg_cnt[63:32] !== 32'd0) begin
         tests_failed++;
         $display("FAIL zlen_cnt got cnt0=%0d cnt1=%0d exp 3/0", msg_cnt[31:0], msg_cnt[63:32]);
      end
      tests_run++;
      if (dst_val !== 1'b0) begin
         tests_failed++;
         $display("FAIL zlen_idle val=%b exp=0", dst_val);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dst_rdy = 1'b1;
      set_src(1, 1'b1, mk_flit(1, 0, 0, 5));
      tick();
      set_src(1, 1'b1, mk_flit(1, 0, 1, 0));
      tick();
      set_src(1, 1'b1, mk_flit(1, 0, 2, 0));
      rst = 1'b1;
      #1;
      tests_run++;
      if (dst_val !== 1'b0 || src_rdy !== 2'b00) begin
         tests_failed++;
         $display("FAIL rmid_gate val=%b rdy=%b exp 0/00", dst_val, src_rdy);
      end
      tick();
      rst = 1'b0;
      set_src(0, 1'b1, mk_flit(0, 9, 0, 0));
      set_src(1, 1'b1, mk_flit(1, 1, 0, 0));
      #1;
      tests_run++;
      if (dst_val !== 1'b1 || dst_data !== mk_flit(0, 9, 0, 0) || src_rdy !== 2'b01) begin
         tests_failed++;
         $display("FAIL rmid_grant val=%b rdy=%b got=%h exp=%h", dst_val, src_rdy, dst_data, mk_flit(0, 9, 0, 0));
      end
      tests_run++;
      if (msg_cnt !== 64'h0) begin
         tests_failed++;
         $display("FAIL rmid_cnt got=%h exp=0", msg_cnt);
      end
      $display("[TB] rmid: after reset grant src=%0d", dst_data[63:56]);
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_atomicity();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
